bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Produces the packed 4-digit BCD word that the display digit mux reads: digit 0 is in [3:0] and digit 3 is in [15:12].
- Sits between the counter/arithmetic datapath and the display scan logic.
- Uses a start/done handshake and holds its result until the next conversion completes.

Parameters:
- BIN_WIDTH, 14, width of the binary input. 14 bits covers 0..9999.
- DIGITS, 4, number of BCD digits. The output width is 4*DIGITS.
- MAX_VAL, 9999, largest value that can be represented. It must equal 10^DIGITS - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled on a rising edge only while in IDLE.
- bin_in  input  BIN_WIDTH  unsigned binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; bcd_out is valid and updated when it asserts.
- bcd_out  output  4*DIGITS  packed BCD result, least-significant digit in [3:0]; held between conversions.
- overflow  output  1  set when the captured value exceeded MAX_VAL; held with bcd_out.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, shift count=0, working registers cleared. Reset takes effect immediately, including mid-conversion. The partial result is discarded and no done pulse is produced.
- States: IDLE, SHIFT.
- IDLE:
  - done is driven 0 except for the one cycle after completion.
  - If start=1 at an edge: capture bin_in, clear the BCD accumulator, count=0, go to SHIFT, busy=1 from the next cycle.
  - If the captured value > MAX_VAL, set an internal overflow flag.
- SHIFT, each edge:
  1. For every BCD digit of the accumulator that is >= 5, add 3. Each digit is handled independently, 4-bit, and cannot carry.
  2. Shift {accumulator, binary} left by 1. The binary MSB enters the accumulator LSB.
  3. count++.
- Completion: on the edge where count reaches BIN_WIDTH-1 (the BIN_WIDTH-th shift), the following happen together:
  - bcd_out takes the post-shift accumulator, or all digits 4'h9 if the overflow flag is set.
  - overflow output takes the flag.
  - done=1 and busy=0.
  - state returns to IDLE.
- done is forced back to 0 on the following edge.
- Latency: exactly BIN_WIDTH clock edges from the edge that accepts start to the edge that raises done. Overflowing inputs take the same latency.
- busy is high for exactly BIN_WIDTH cycles per conversion.
- start while busy=1 is ignored. It is not queued, and bin_in changes during a conversion have no effect.
- start=1 in the cycle where done=1 is accepted (the FSM is in IDLE). done still drops on the next edge, and busy rises on that same edge.
- Back-to-back conversions are therefore possible with a period of BIN_WIDTH+1 cycles.
- bcd_out and overflow change only on the completion edge or on reset. They stay stable through the whole of a following conversion.
- Every digit of bcd_out is always in the range 0..9.
- Width rules:
  - Accumulator is 4*DIGITS bits; the binary shift register is BIN_WIDTH bits.
  - Overflow compare is an unsigned compare at BIN_WIDTH bits.
  - With the defaults, 16383 is the largest input that can be applied, and it is flagged as overflow.

Test Plan:
1. Assert rst_n=0 mid-simulation with garbage inputs -> bcd_out=16'h0000, busy=0, done=0, overflow=0 immediately, with no clock edge needed.
2. start pulse with bin_in=1234 -> busy high for 14 cycles; done pulses exactly 14 edges after the accepting edge; bcd_out=16'h1234, overflow=0. Repeat for 0 -> 16'h0000, 9999 -> 16'h9999, and 5 -> 16'h0005.
3. bin_in=10000 and bin_in=16383 -> latency is still 14 edges; bcd_out=16'h9999, overflow=1. A following conversion of 42 returns 16'h0042 with overflow=0.
4. Convert 1234, then pulse start with bin_in=777 at cycle 5 of the conversion and change bin_in mid-conversion -> result is 16'h1234, only one done pulse, and the second start is ignored.
5. Hold start=1 continuously with bin_in=0..20 stepping after each done -> conversions occur every 15 cycles and each result equals the BCD of its captured value. bcd_out is stable between done pulses.
6. Start a conversion of 8888 and drop rst_n at cycle 7 -> outputs clear at once, no done pulse follows. A new start after release converts 8888 -> 16'h8888.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Result and overflow are held until the next conversion completes.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4,
  parameter int MAX_VAL   = 9999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BIN_WIDTH-1:0] MAX_BIN  = BIN_WIDTH'(MAX_VAL);
  localparam logic [ACC_W-1:0]     ALL_NINE = {DIGITS{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [BIN_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 flag_q, flag_d;
  logic [ACC_W-1:0]     bcd_d;
  logic                 ovf_d;
  logic                 done_d;
  logic [ACC_W-1:0]     adj;
  logic [ACC_W-1:0]     shifted_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      bcd_out  <= bcd_d;
      overflow <= ovf_d;
      done     <= done_d;
    end
  end

  // Add-3 per digit is 4-bit wide and never carries into the next digit.
  always_comb begin
    adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    shifted_acc = {adj[ACC_W-2:0], sr_q[BIN_WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    bcd_d   = bcd_out;
    ovf_d   = overflow;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          flag_d  = (bin_in > MAX_BIN);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = shifted_acc;
        sr_d  = {sr_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = flag_q ? ALL_NINE : shifted_acc;
          ovf_d   = flag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: transaction-level model compared
// every cycle, plus directed conversions with literal expected results.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  bin_to_bcd_seq #(.BIN_WIDTH(14), .DIGITS(4), .MAX_VAL(9999)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    if (v > 9999) return 16'h9999;
    p = 1;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a conversion accepted in idle completes 14 edges later.
  int          m_left;
  int          m_val;
  logic        m_done;
  logic [15:0] m_bcd;
  logic        m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_val  <= 0;
      m_done <= 1'b0;
      m_bcd  <= '0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left <= 14;
          m_val  <= int'(bin_in);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_bcd  <= bcd_of(m_val);
          m_ovf  <= (m_val > 9999);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
    check("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (done === 1'b1) done_cnt++;
  end

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic convert(input int val, input logic [15:0] exp_bcd, input logic exp_ovf);
    int k;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'(val);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'h2aaa;
    wait_done(k);
    check($sformatf("latency_%0d", val), 32'(k), 32'd14);
    check($sformatf("bcd_%0d", val), 32'(bcd_out), 32'(exp_bcd));
    check($sformatf("ovf_%0d", val), 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    int k;
    int d0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #1;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic conversions
    convert(1234, 16'h1234, 1'b0);
    convert(0, 16'h0000, 1'b0);
    convert(9999, 16'h9999, 1'b0);
    convert(5, 16'h0005, 1'b0);
    convert(10000, 16'h9999, 1'b1);
    convert(16383, 16'h9999, 1'b1);
    convert(42, 16'h0042, 1'b0);

    // Start during a conversion is ignored, bin_in changes have no effect
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd1234;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    repeat (5) begin @(negedge clk); k++; end
    start  = 1'b1;
    bin_in = 14'd777;
    @(negedge clk);
    k++;
    start  = 1'b0;
    bin_in = 14'd3000;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("ignore_latency", 32'(k), 32'd14);
    check("ignore_bcd", 32'(bcd_out), 32'h1234);
    repeat (20) @(negedge clk);
    check("ignore_single_done", 32'(done_cnt - d0), 32'd1);
    check("ignore_idle", 32'(busy), 32'd0);

    // Back-to-back with start held high, period 15
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd0;
    @(negedge clk);
    for (int v = 0; v <= 20; v++) begin
      wait_done(k);
      check($sformatf("b2b_period_%0d", v), 32'(k), 32'd14);
      check($sformatf("b2b_bcd_%0d", v), 32'(bcd_out), 32'(bcd_of(v)));
      if (v < 20) bin_in = 14'(v + 1);
      else        start = 1'b0;
      @(negedge clk);
    end
    check("b2b_last", 32'(bcd_out), 32'h0020);

    // Reset mid-conversion with garbage inputs
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd8888;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst_n  = 1'b0;
    start  = 1'b1;
    bin_in = 14'h3abc;
    #1;
    check("async_rst_bcd", 32'(bcd_out), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    check("async_rst_ovf", 32'(overflow), 32'h0);
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    convert(8888, 16'h8888, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
